// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP front/back end and the neuron layers.
package mlp_pkg;

    localparam int W       = 16;   // word width, signed two's complement
    localparam int N_PIX   = 784;  // pixels per frame
    localparam int N_CLASS = 10;   // scores / classes
    localparam int CNT_W   = 10;   // pixel counter width, holds 0..N_PIX-1
    localparam int CLS_W   = 4;    // class index width, holds 0..N_CLASS-1

    typedef logic signed [W-1:0] word_t;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_SCAN = 2'd2,
        S_OUT  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/argmax_scan.sv
// Sequential argmax over the N_CLASS network scores, one compare per cycle.
// A start pulse arms the scan; the first scan cycle compares score[1]
// against score[0] directly, so scores are only looked at while scanning.
module argmax_scan
    import mlp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_CLASS*W-1:0]   score,
    output logic                   done,
    output logic [CLS_W-1:0]       best_idx,
    output logic [W-1:0]           best_val
);

    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLASS - 1);

    word_t            score_a [N_CLASS];
    logic [CLS_W-1:0] idx_r;
    logic             busy_r;
    logic             first_r;
    logic [CLS_W-1:0] best_idx_r;
    word_t            best_val_r;

    word_t            cand_s;
    word_t            base_val_s;
    logic [CLS_W-1:0] base_idx_s;
    logic             take_s;

    for (genvar g = 0; g < N_CLASS; g++) begin : g_unpack
        assign score_a[g] = word_t'(score[g*W +: W]);
    end

    // Pick the candidate score and the running best it competes against.
    always_comb begin
        cand_s     = score_a[0];
        base_val_s = best_val_r;
        base_idx_s = best_idx_r;
        if (idx_r < CLS_W'(N_CLASS)) begin
            cand_s = score_a[idx_r];
        end else begin
            cand_s = score_a[0];
        end
        if (first_r) begin
            base_val_s = score_a[0];
            base_idx_s = {CLS_W{1'b0}};
        end else begin
            base_val_s = best_val_r;
            base_idx_s = best_idx_r;
        end
        // Strictly greater keeps the lowest index on ties.
        take_s = (cand_s > base_val_s);
    end

    // Scan counter and running best registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r      <= {CLS_W{1'b0}};
            busy_r     <= 1'b0;
            first_r    <= 1'b0;
            best_idx_r <= {CLS_W{1'b0}};
            best_val_r <= {W{1'b0}};
        end else if (start) begin
            idx_r   <= CLS_W'(1);
            busy_r  <= 1'b1;
            first_r <= 1'b1;
        end else if (busy_r) begin
            first_r <= 1'b0;
            if (take_s) begin
                best_idx_r <= idx_r;
                best_val_r <= cand_s;
            end else begin
                best_idx_r <= base_idx_s;
                best_val_r <= base_val_s;
            end
            if (idx_r == LAST_IDX) begin
                busy_r <= 1'b0;
                idx_r  <= {CLS_W{1'b0}};
            end else begin
                idx_r <= idx_r + CLS_W'(1);
            end
        end
    end

    assign done     = busy_r && (idx_r == LAST_IDX);
    assign best_idx = best_idx_r;
    assign best_val = best_val_r;

endmodule

// File: rtl/mlp_frame_driver.sv
// Frame loader and classifier output stage for the combinational MLP.
// Collects N_PIX pixels into the image buffer, waits SETTLE cycles for the
// network to settle, scans the scores for the argmax and presents the class.
module mlp_frame_driver
    import mlp_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [W-1:0]           s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [N_PIX*W-1:0]     image,
    input  logic [N_CLASS*W-1:0]   score,
    output logic                   m_valid,
    output logic [CLS_W-1:0]       m_class,
    output logic [W-1:0]           m_score,
    input  logic                   m_ready,
    output logic                   err_len
);

    localparam int                WAIT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(N_PIX - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(SETTLE - 1);

    drv_state_t        state_r;
    drv_state_t        state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    word_t             image_r [N_PIX];
    logic              err_len_r;
    logic              m_valid_r;

    logic              accept_s;
    logic              frame_ok_s;
    logic              frame_err_s;
    logic              scan_start_s;
    logic              scan_done_s;

    argmax_scan u_argmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (scan_start_s),
        .score    (score),
        .done     (scan_done_s),
        .best_idx (m_class),
        .best_val (m_score)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        frame_ok_s   = 1'b0;
        frame_err_s  = 1'b0;
        scan_start_s = 1'b0;
        case (state_r)
            S_LOAD: begin
                if (s_valid) begin
                    accept_s = 1'b1;
                    if ((cnt_r == LAST_PIX) && s_last) begin
                        frame_ok_s   = 1'b1;
                        state_next_s = S_WAIT;
                    end else if ((cnt_r == LAST_PIX) || s_last) begin
                        frame_err_s  = 1'b1;
                        state_next_s = S_LOAD;
                    end else begin
                        state_next_s = S_LOAD;
                    end
                end else begin
                    state_next_s = S_LOAD;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == LAST_WAIT) begin
                    scan_start_s = 1'b1;
                    state_next_s = S_SCAN;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_SCAN: begin
                if (scan_done_s) begin
                    state_next_s = S_OUT;
                end else begin
                    state_next_s = S_SCAN;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    state_next_s = S_LOAD;
                end else begin
                    state_next_s = S_OUT;
                end
            end
            default: begin
                state_next_s = S_LOAD;
            end
        endcase
    end

    // Pixel buffer, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r      <= {CNT_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            err_len_r  <= 1'b0;
            m_valid_r  <= 1'b0;
            for (int k = 0; k < N_PIX; k++) begin
                image_r[k] <= {W{1'b0}};
            end
        end else begin
            if (accept_s) begin
                image_r[cnt_r] <= word_t'(s_data);
            end
            if (frame_ok_s || frame_err_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (accept_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r == S_WAIT) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
            err_len_r <= frame_err_s;
            m_valid_r <= (state_next_s == S_OUT);
        end
    end

    for (genvar g = 0; g < N_PIX; g++) begin : g_pack
        assign image[g*W +: W] = image_r[g];
    end

    // Ready only in LOAD, and never while reset is being applied.
    assign s_ready = rst_n & (state_r == S_LOAD);
    assign m_valid = m_valid_r;
    assign err_len = err_len_r;

endmodule

// File: tb/tb_mlp_frame_driver.sv
// Directed self-checking bench for mlp_frame_driver (SETTLE = 4).
`timescale 1ns/1ps
module tb_mlp_frame_driver;
    import mlp_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_valid;
    logic [15:0]          s_data;
    logic                 s_last;
    logic                 s_ready;
    logic [N_PIX*16-1:0]  image;
    logic [N_CLASS*16-1:0] score;
    logic                 m_valid;
    logic [3:0]           m_class;
    logic [15:0]          m_score;
    logic                 m_ready;
    logic                 err_len;

    logic [15:0]          sc [N_CLASS];
    int                   checks = 0;
    int                   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_CLASS; g++) begin : g_score
        assign score[g*16 +: 16] = sc[g];
    end

    mlp_frame_driver #(.SETTLE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .image   (image),
        .score   (score),
        .m_valid (m_valid),
        .m_class (m_class),
        .m_score (m_score),
        .m_ready (m_ready),
        .err_len (err_len)
    );

    // Drive n_beats pixels (value base+i); s_last on beat last_at. Returns
    // right after the final beat is placed on the bus.
    task automatic drive_frame(input int n_beats, input int last_at,
                               input logic [15:0] base, input bit bubbles);
        for (int i = 0; i < n_beats; i++) begin
            @(negedge clk);
            if (bubbles && ($urandom_range(0, 3) == 0)) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = base + 16'(i);
            s_last  = (i == last_at);
        end
    endtask

    // Cycles from the last beat until m_valid is seen; -1 if it never comes.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            if (m_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 16'h0000; s_last = 1'b0; m_ready = 1'b0;
        for (int k = 0; k < N_CLASS; k++) sc[k] = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b, expected 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
        checks++; if (m_class !== 4'd0) begin errors++; $display("FAIL reset_m_class: got %0d, expected 0", m_class); end
        checks++; if (m_score !== 16'h0000) begin errors++; $display("FAIL reset_m_score: got %h, expected 0000", m_score); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len: got %b, expected 0", err_len); end
        checks++; if (image !== '0) begin errors++; $display("FAIL reset_image: nonzero words, expected all 0"); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %b, expected 1", s_ready); end
    endtask

    task automatic test_nominal();
        int lat;
        int bad;
        for (int k = 0; k < N_CLASS; k++) sc[k] = 16'(k);
        sc[7] = 16'h0100;
        drive_frame(N_PIX, N_PIX - 1, 16'h0000, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 14) begin errors++; $display("FAIL nominal_latency: got %0d, expected 14", lat); end
        checks++; if (m_class !== 4'd7) begin errors++; $display("FAIL nominal_class: got %0d, expected 7", m_class); end
        checks++; if (m_score !== 16'h0100) begin errors++; $display("FAIL nominal_score: got %h, expected 0100", m_score); end
        bad = 0;
        for (int k = 0; k < N_PIX; k++) if (image[k*16 +: 16] !== 16'(k)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL nominal_image: %0d words wrong, expected 0", bad); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL nominal_handshake_m_valid: got %b, expected 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL nominal_handshake_s_ready: got %b, expected 1", s_ready); end
    endtask

    task automatic test_tie();
        int lat;
        for (int k = 0; k < N_CLASS; k++) sc[k] = 16'h0010;
        sc[0] = 16'hFFF0;
        sc[2] = 16'h0200;
        sc[5] = 16'h0200;
        drive_frame(N_PIX, N_PIX - 1, 16'h0300, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 14) begin errors++; $display("FAIL tie_latency: got %0d, expected 14", lat); end
        checks++; if (m_class !== 4'd2) begin errors++; $display("FAIL tie_class: got %0d, expected 2", m_class); end
        checks++; if (m_score !== 16'h0200) begin errors++; $display("FAIL tie_score: got %h, expected 0200", m_score); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_signed();
        int lat;
        for (int k = 0; k < N_CLASS - 1; k++) sc[k] = 16'(-(5 + k));
        sc[3] = 16'h8000;
        sc[9] = 16'hFFFF;
        drive_frame(N_PIX, N_PIX - 1, 16'h0040, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 14) begin errors++; $display("FAIL signed_latency: got %0d, expected 14", lat); end
        checks++; if (m_class !== 4'd9) begin errors++; $display("FAIL signed_class: got %0d, expected 9", m_class); end
        checks++; if (m_score !== 16'hFFFF) begin errors++; $display("FAIL signed_score: got %h, expected ffff", m_score); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_early_last();
        int lat;
        int bad;
        int seen;
        int not_ready;
        // s_last on beat 100
        drive_frame(101, 100, 16'h7000, 1'b0);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL early_err_pulse: got %b, expected 1", err_len); end
        @(negedge clk);
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL early_err_width: got %b, expected 0", err_len); end
        seen = 0; not_ready = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen++;
            if (s_ready !== 1'b1) not_ready++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL early_no_result: m_valid high %0d cycles, expected 0", seen); end
        checks++; if (not_ready !== 0) begin errors++; $display("FAIL early_s_ready: low %0d cycles, expected 0", not_ready); end
        // beat 783 without s_last
        drive_frame(N_PIX, -1, 16'h2000, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL nolast_err_pulse: got %b, expected 1", err_len); end
        @(negedge clk);
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL nolast_err_width: got %b, expected 0", err_len); end
        // full frame with bubbles classifies normally
        for (int k = 0; k < N_CLASS; k++) sc[k] = 16'(3 * k);
        sc[4] = 16'h0400;
        drive_frame(N_PIX, N_PIX - 1, 16'h1000, 1'b1);
        wait_result(lat);
        checks++; if (lat !== 14) begin errors++; $display("FAIL recover_latency: got %0d, expected 14", lat); end
        checks++; if (m_class !== 4'd4) begin errors++; $display("FAIL recover_class: got %0d, expected 4", m_class); end
        checks++; if (m_score !== 16'h0400) begin errors++; $display("FAIL recover_score: got %h, expected 0400", m_score); end
        bad = 0;
        for (int k = 0; k < N_PIX; k++) if (image[k*16 +: 16] !== (16'h1000 + 16'(k))) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL recover_image: %0d words wrong, expected 0", bad); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        int lat;
        for (int k = 0; k < N_CLASS; k++) sc[k] = 16'(10 * k);
        drive_frame(N_PIX, N_PIX - 1, 16'h0500, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 14) begin errors++; $display("FAIL bp_latency: got %0d, expected 14", lat); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 5) begin
                sc[0] = 16'h7FFF;
                s_valid = 1'b1;
                s_data  = 16'hDEAD;
            end
            checks++;
            if (m_valid !== 1'b1 || m_class !== 4'd9 || m_score !== 16'h005A || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b class=%0d score=%h ready=%b, expected 1/9/005a/0",
                         k, m_valid, m_class, m_score, s_ready);
            end
        end
        s_valid = 1'b0;
        checks++; if (image[15:0] !== 16'h0500) begin errors++; $display("FAIL bp_image_frozen: got %h, expected 0500", image[15:0]); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b, expected 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b, expected 0", m_valid); end
    endtask

    task automatic test_reset_scan();
        int seen;
        for (int k = 0; k < N_CLASS; k++) sc[k] = 16'(k);
        drive_frame(N_PIX, N_PIX - 1, 16'h0100, 1'b0);
        repeat (6) begin
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0;
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rscan_in_scan: m_valid got %b, expected 0", m_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rscan_m_valid: got %b, expected 0", m_valid); end
        checks++; if (image !== '0) begin errors++; $display("FAIL rscan_image: nonzero words, expected all 0"); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rscan_s_ready_in_reset: got %b, expected 0", s_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rscan_s_ready_after: got %b, expected 1", s_ready); end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rscan_result_lost: m_valid high %0d cycles, expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_tie();
        test_signed();
        test_early_last();
        test_back_pressure();
        test_reset_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
